// File: rtl/riscv_imem.sv
// Instruction memory for the RISC-V fetch stage: a program-load port used in LOAD, registered fetch in RUN.
// Optional build macro RISCV_IMEM_ALIGN_CHECK_EN makes a misaligned pc fault like an out-of-range one.
module riscv_imem #(
    parameter int          AW  = 5,
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble,
    input  logic [31:0]   pc,
    output logic [31:0]   instruction,
    output logic          valid,
    output logic          fault,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          load_done,
    output logic          load_err,
    output logic          dbg_state
);

    localparam logic ST_LOAD = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam int   DEPTH   = 1 << AW;

`ifdef RISCV_IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic          state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] index;
    logic          out_of_range;
    logic          misaligned;
    logic          bad_fetch;

    assign dbg_state = state;

    // valid=1 means instruction carries a word fetched from mem this or an earlier
    // (stalled) cycle; there is no ready: the consumer stalls us through bubble.
    always_comb begin
        index        = pc[AW+1:2];
        out_of_range = |pc[31:AW+2];
        misaligned   = ALIGN_CHECK && (|pc[1:0]);
        bad_fetch    = out_of_range || misaligned;
    end

    // Contents survive reset so a program can be rerun without reloading.
    always_ff @(posedge clk) begin
        if (rst && state == ST_LOAD && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_LOAD;
            instruction <= NOP;
            valid       <= 1'b0;
            fault       <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            load_err <= (state == ST_RUN) && load_en;
            case (state)
                ST_LOAD: begin
                    instruction <= NOP;
                    valid       <= 1'b0;
                    fault       <= 1'b0;
                    if (load_done) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (!bubble) begin
                        if (bad_fetch) begin
                            instruction <= NOP;
                            valid       <= 1'b0;
                            fault       <= 1'b1;
                        end else begin
                            instruction <= mem[index];
                            valid       <= 1'b1;
                            fault       <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_imem.sv
// Bench for riscv_imem: reset checks, a directed vector table, corner sequences, and a
// randomized run scored against a word-array model of the memory.
module tb_riscv_imem;

    localparam int          AW    = 5;
    localparam int          DEPTH = 32;
    localparam logic [31:0] NOP   = 32'h00000013;
`ifdef RISCV_IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          bubble;
    logic [31:0]   pc;
    logic [31:0]   instruction;
    logic          valid;
    logic          fault;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          load_err;
    logic          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [34:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        bubble;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_fault;
    } vec_t;
    vec_t vecs[10];

    riscv_imem #(.AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .bubble(bubble), .pc(pc),
        .instruction(instruction), .valid(valid), .fault(fault),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] ei, input logic ev, input logic ef);
        check({name, ".instruction"}, instruction, ei);
        check({name, ".valid"}, {31'd0, valid}, {31'd0, ev});
        check({name, ".fault"}, {31'd0, fault}, {31'd0, ef});
    endtask

    // driver tasks
    task automatic load_word(input int addr, input logic [31:0] data, input logic done);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        load_done = done;
        tick();
        load_en   = 1'b0;
        load_done = 1'b0;
        ref_mem[addr] = data;
    endtask

    task automatic fetch(input logic [31:0] p, input logic b);
        pc     = p;
        bubble = b;
        tick();
    endtask

    // reference model: what a fresh (non-stalled) fetch of pc returns
    function automatic logic [33:0] predict(input logic [31:0] p);
        if (p >= 32'(DEPTH * 4) || (ALIGN && (p % 4) != 0))
            return {NOP, 1'b0, 1'b1};
        return {ref_mem[(p / 4) % DEPTH], 1'b1, 1'b0};
    endfunction

    initial begin
        logic [33:0] model_out;
        logic [34:0] e;
        logic [31:0] rp;
        logic        rb, rl;

        rst = 1'b0; bubble = 1'b0; pc = 32'd12;
        load_en = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        tick();
        tick();
        check_out("reset", NOP, 1'b0, 1'b0);
        check("reset.load_err", {31'd0, load_err}, 32'd0);
        check("reset.state", {31'd0, dbg_state}, 32'd0);
        rst = 1'b1;

        // Program load: random filler, then the known words.
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom, 1'b0);
        load_word(0, 32'h02A00293, 1'b0);
        load_word(1, 32'h00100093, 1'b0);
        load_word(2, 32'hCAFEF00D, 1'b0);
        load_word(3, 32'hDEADBEEF, 1'b0);
        check_out("load_idle", NOP, 1'b0, 1'b0);
        check("load.state", {31'd0, dbg_state}, 32'd0);
        // Write and load_done in the same cycle: the write must still commit.
        load_word(31, 32'h12345678, 1'b1);
        check_out("after_done", NOP, 1'b0, 1'b0);
        check("run.state", {31'd0, dbg_state}, 32'd1);

        fetch(32'd12, 1'b0);
        check_out("first_fetch_pc12", 32'hDEADBEEF, 1'b1, 1'b0);
        fetch(32'd0, 1'b0);
        check_out("li_t0_42", 32'h02A00293, 1'b1, 1'b0);
        check("li.rd", {27'd0, instruction[11:7]}, 32'd5);
        check("li.rs1", {27'd0, instruction[19:15]}, 32'd0);
        check("li.imm", {{20{instruction[31]}}, instruction[31:20]}, 32'd42);

        // Directed vectors: stall hold, release, range and alignment edges.
        vecs[0] = '{32'h00000000, 1'b0, 32'h02A00293, 1'b1, 1'b0};
        vecs[1] = '{32'h00000004, 1'b1, 32'h02A00293, 1'b1, 1'b0};
        vecs[2] = '{32'h00000004, 1'b1, 32'h02A00293, 1'b1, 1'b0};
        vecs[3] = '{32'h00000004, 1'b1, 32'h02A00293, 1'b1, 1'b0};
        vecs[4] = '{32'h00000004, 1'b0, 32'h00100093, 1'b1, 1'b0};
        vecs[5] = '{32'h00000080, 1'b0, NOP, 1'b0, 1'b1};
        vecs[6] = '{32'h00000008, 1'b1, NOP, 1'b0, 1'b1};
        vecs[7] = '{32'h00000002, 1'b0, ALIGN ? NOP : 32'h02A00293, !ALIGN, ALIGN};
        vecs[8] = '{32'h0000007C, 1'b0, 32'h12345678, 1'b1, 1'b0};
        vecs[9] = '{32'hFFFFFFFC, 1'b0, NOP, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            fetch(vecs[i].pc, vecs[i].bubble);
            check_out($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_valid, vecs[i].exp_fault);
        end

        // Rejected write in RUN: one-cycle load_err, memory untouched.
        pc = 32'd0; bubble = 1'b0;
        load_en = 1'b1; load_addr = '0; load_data = 32'hFFFFFFFF;
        tick();
        load_en = 1'b0;
        check("load_err.pulse", {31'd0, load_err}, 32'd1);
        tick();
        check("load_err.clear", {31'd0, load_err}, 32'd0);
        check_out("mem0_unchanged", 32'h02A00293, 1'b1, 1'b0);

        // Randomized run scored against the model.
        model_out = {32'h02A00293, 1'b1, 1'b0};
        for (int i = 0; i < 300; i++) begin
            rp = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, DEPTH * 4 - 1)) : $urandom;
            rb = ($urandom_range(0, 3) == 0);
            rl = ($urandom_range(0, 4) == 0);
            if (!rb) model_out = predict(rp);
            exp_q.push_back({model_out, rl});
            pc = rp; bubble = rb;
            load_en = rl; load_addr = AW'($urandom); load_data = $urandom;
            tick();
            e = exp_q.pop_front();
            check_out($sformatf("rand%0d", i), e[34:3], e[2], e[1]);
            check($sformatf("rand%0d.load_err", i), {31'd0, load_err}, {31'd0, e[0]});
        end
        load_en = 1'b0;

        // Reset mid-RUN returns to LOAD; contents survive so load_done alone restarts.
        rst = 1'b0; pc = 32'd12; bubble = 1'b0;
        tick();
        check_out("midrun_reset", NOP, 1'b0, 1'b0);
        check("midrun_reset.state", {31'd0, dbg_state}, 32'd0);
        rst = 1'b1;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check_out("rerun_done", NOP, 1'b0, 1'b0);
        fetch(32'd12, 1'b0);
        check_out("rerun_fetch", 32'hDEADBEEF, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_imem.md
# riscv_imem

Instruction memory responder for the RISC-V fetch stage: it takes the program counter from `riscv_if` and returns the instruction word registered for `riscv_id`. It replaces the ad-hoc memory array benches currently build by hand. It also owns a program-load port, used after reset, and an explicit LOAD→RUN state so fetch never sees a half-written program.

## Interface
Parameters:
- `AW`, 5, word-address width; the memory holds 2^AW 32-bit words.
- `NOP`, 32'h00000013, instruction driven when no valid fetch data exists (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `bubble`  in  1  stall; holds the fetch output.
- `pc`  in  32  byte address from `riscv_if`.
- `instruction`  out  32  registered fetch data to `riscv_id`.
- `valid`  out  1  `instruction` holds real fetched data.
- `fault`  out  1  the last fetch was out of range or misaligned.
- `load_en`  in  1  write strobe for the load port.
- `load_addr`  in  AW  word index of the write.
- `load_data`  in  32  write data.
- `load_done`  in  1  ends program load.
- `load_err`  out  1  one-cycle pulse when `load_en` is rejected.

## Operation
- **States.**
  - Two states, LOAD and RUN. Reset enters LOAD.
  - LOAD→RUN on a `load_done` sample of 1.
  - RUN→LOAD only through reset.
- **LOAD.**
  - `load_en`=1 writes `mem[load_addr] <= load_data`.
  - Fetch is idle: `instruction`=NOP, `valid`=0, `fault`=0.
- **RUN.**
  - `load_en`=1 is ignored and `load_err` pulses high for one cycle.
  - Word index is `pc[AW+1:2]`.
  - A pc is out of range if `pc[31:AW+2]` is nonzero.
- **Fetch, in RUN with `bubble`=0, on each edge:**
  - Out-of-range pc (or misaligned, see Configuration): `instruction`<=NOP, `valid`<=0, `fault`<=1.
  - Otherwise: `instruction`<=mem[index], `valid`<=1, `fault`<=0.
- **Stall.** `bubble`=1 holds `instruction`, `valid` and `fault` unchanged; `pc` is ignored.
- **Simultaneous events.**
  - `load_en` and `load_done` in the same LOAD cycle: the write commits and the state moves to RUN.
  - The first RUN fetch therefore sees that write.
- **Reset mid-operation.**
  - All outputs and the state return to reset values.
  - Memory contents are retained, not cleared, so a reset can be followed directly by `load_done`.

## Timing
- Reset values: `instruction`=NOP, `valid`=0, `fault`=0, `load_err`=0, state=LOAD.
- Fetch latency is 1 cycle: `pc` sampled at edge N gives `instruction` valid after edge N.
- Into `riscv_id`, which registers again, the fetch-to-decode path is 2 ticks after reset release.
- `load_done` sampled at edge N: the state is RUN after N, and the first fetch is captured at edge N+1.
- Writes take effect at the sampling edge. A read of the same index in a later cycle returns the new data; there is no same-cycle read in LOAD.
- `load_err` is high for exactly the cycle after the rejected strobe. Back-to-back rejected strobes keep it high.
- Memory is a plain registered array; no read-during-write forwarding is needed, because writes and reads never overlap in time.

## Configuration
- `RISCV_IMEM_ALIGN_CHECK_EN` defined: a RUN fetch with `pc[1:0]`≠0 is treated like out of range (`fault`<=1, `valid`<=0, NOP).
- Undefined: `pc[1:0]` is ignored and the fetch returns mem[`pc[AW+1:2]`] with `fault`=0. Only the range check remains.

## Test plan
- Load `mem[0]`=32'h02A00293 (`li t0,42`), pulse `load_done`, then hold pc=0 and `bubble`=0. After 1 tick: `instruction`=32'h02A00293, `valid`=1, `fault`=0. Chained into `riscv_id`: `rd`=5, `a`=0, `b`=42.
- During LOAD, write index 3 = 32'hDEADBEEF, then go to RUN with pc=12. Result: `instruction`=32'hDEADBEEF. Before `load_done`, outputs stay `valid`=0 and `instruction`=NOP.
- In RUN, assert `bubble`=1 and change pc from 0 to 4 for 3 cycles. Outputs hold the pc=0 word. Dropping `bubble` shows the pc=4 word one tick later.
- Out-of-range pc=32'h00000080 with AW=5 gives `fault`=1, `valid`=0, NOP. Repeat with pc=2: `fault`=1 with the macro defined, else mem[0] with `fault`=0.
- In RUN, `load_en`=1 to index 0 gives a `load_err` pulse for 1 cycle, and mem[0] is unchanged on the next fetch.
- Assert `rst`=0 mid-RUN: the next edge gives NOP, `valid`=0, state LOAD. Then `load_done` followed by a fetch still returns the pre-reset contents.
